// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern detector.
package seq_pkg;

   // Detector state: still collecting the first N bits, or holding a full window
   typedef enum logic {
      FILL  = 1'b0,
      ARMED = 1'b1
   } seqState_t;

   localparam int         DEF_N       = 4;
   localparam logic [3:0] DEF_PATTERN = 4'b1011;

   // Bits needed for a fill counter that must reach the value n itself
   function automatic int fillWidth(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_shift_win.sv
// N-bit MSB-first shift window with a saturating fill counter.
// The look-ahead window value is exported so the comparator can judge the
// bit being accepted on this edge; flush wins over shift.
module seq_shift_win
   import seq_pkg::*;
#(
   parameter int N = DEF_N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_shift,
   input  logic         i_bit,
   input  logic         i_flush,
   output logic [N-1:0] o_winNext,
   output logic         o_full,
   output logic         o_almostFull
);

   localparam int                 FILL_W   = fillWidth(N);
   localparam logic [FILL_W-1:0] FULL_CNT = FILL_W'(N);
   localparam logic [FILL_W-1:0] ALMOST   = FILL_W'(N - 1);

   logic [N-1:0]      r_win;
   logic [FILL_W-1:0] r_fill;
   logic [N-1:0]      w_shifted;

   // Look-ahead window: what the register will hold if this bit is shifted in
   always_comb begin
      w_shifted    = {r_win[N-2:0], i_bit};
      o_winNext    = i_shift ? w_shifted : r_win;
      o_full       = (r_fill == FULL_CNT);
      o_almostFull = (r_fill == ALMOST);
   end

   // Window and fill counter; the counter stops at N once the window is full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_win  <= '0;
         r_fill <= '0;
      end else if (i_flush) begin
         r_win  <= '0;
         r_fill <= '0;
      end else if (i_shift) begin
         r_win <= w_shifted;
         if (r_fill != FULL_CNT) begin
            r_fill <= r_fill + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: checker for the sequence-generator link.
// Flags each occurrence of PATTERN (first received bit against PATTERN[N-1]),
// counts matches with saturation and keeps a sticky seen flag.
// Build option: define SEQ_DETECTOR_OVERLAP_EN to allow overlapping matches;
// without it a match flushes the window so the next match needs N fresh bits.
module seq_detector
   import seq_pkg::*;
#(
   parameter int           N       = DEF_N,
   parameter logic [N-1:0] PATTERN = DEF_PATTERN,
   parameter int           COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               bit_i,
   input  logic               valid_i,
   input  logic               count_clr,
   output logic               match,
   output logic [COUNT_W-1:0] match_cnt,
   output logic               seen,
   output logic               armed
);

   logic [N-1:0] w_winNext;
   logic         w_full;
   logic         w_almostFull;
   logic         w_fullNext;
   logic         w_hit;
   logic         w_flush;
   seqState_t    r_state;

   seq_shift_win #(
      .N(N)
   ) u_win (
      .clk         (clk),
      .rst         (rst),
      .i_shift     (valid_i),
      .i_bit       (bit_i),
      .i_flush     (w_flush),
      .o_winNext   (w_winNext),
      .o_full      (w_full),
      .o_almostFull(w_almostFull)
   );

   // Comparator on the look-ahead window; a partly filled window never matches
   always_comb begin
      w_fullNext = w_full | (valid_i & w_almostFull);
      w_hit      = valid_i & w_fullNext & (w_winNext == PATTERN);
`ifdef SEQ_DETECTOR_OVERLAP_EN
      w_flush    = 1'b0;
`else
      w_flush    = w_hit;
`endif
   end

   // FSM with registered match pulse, saturating counter, sticky flag and armed
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= FILL;
         armed     <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
         seen      <= 1'b0;
      end else begin
         match <= w_hit;
         if (w_hit) begin
            seen <= 1'b1;
         end
         if (count_clr) begin
            match_cnt <= COUNT_W'(w_hit);
         end else if (w_hit && (match_cnt != {COUNT_W{1'b1}})) begin
            match_cnt <= match_cnt + 1'b1;
         end
         case (r_state)
            FILL: begin
               if (w_fullNext && !w_flush) begin
                  r_state <= ARMED;
                  armed   <= 1'b1;
               end
            end
            ARMED: begin
               if (w_flush) begin
                  r_state <= FILL;
                  armed   <= 1'b0;
               end
            end
            default: begin
               r_state <= FILL;
               armed   <= 1'b0;
            end
         endcase
      end
   end

endmodule
